// File: rtl/alu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_sequencer_pkg
// Shared definitions for the ALU sequencer slice: ALU opcode encodings,
// sequencer FSM state encodings and the latency counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_sequencer_pkg;

   // ALU opcodes as seen on cmd_opcode / alu_opcode
   typedef enum logic [2:0] {
      OP_ADD_U = 3'd0,
      OP_ADD_S = 3'd1,
      OP_SUB_U = 3'd2,
      OP_SUB_S = 3'd3,
      OP_AND   = 3'd4,
      OP_OR    = 3'd5,
      OP_XOR   = 3'd6,
      OP_SHL   = 3'd7
   } alu_op_e;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } seq_state_e;

   // Latency counter width; ALU_LATENCY is limited to 1..15
   localparam int LAT_W = 4;

endpackage : alu_sequencer_pkg

// File: rtl/alu_flag_gen.sv
// -----------------------------------------------------------------------------
// alu_flag_gen
// Purely combinational carry/overflow generation for the sequencer, computed
// from the held operands rather than taken from the ALU.
// Ports:
//   opcode_i   [2:0]          ALU opcode (alu_op_e encoding)
//   a_i, b_i   [NUMBITS-1:0]  operands
//   carry_o                   carry (add) / borrow (sub) / shifted-out MSB (shl)
//   overflow_o                two's-complement overflow for signed add/sub
// -----------------------------------------------------------------------------
module alu_flag_gen
   import alu_sequencer_pkg::*;
#(
   parameter int NUMBITS = 32
) (
   input  logic [2:0]         opcode_i,
   input  logic [NUMBITS-1:0] a_i,
   input  logic [NUMBITS-1:0] b_i,
   output logic               carry_o,
   output logic               overflow_o
);

   localparam int MSB = NUMBITS - 1;

   logic [NUMBITS-2:0] a_lo_s;
   logic [NUMBITS-2:0] b_lo_s;
   logic               a_msb_s;
   logic               b_msb_s;
   logic               c_add_s;     // carry into the MSB for A+B
   logic               c_sub_s;     // carry into the MSB for A+~B+1
   logic               cout_add_s;  // bit NUMBITS of the (NUMBITS+1)-bit A+B
   logic               cout_sub_s;  // bit NUMBITS of A+~B+1; borrow is its inverse

   assign a_lo_s  = a_i[NUMBITS-2:0];
   assign b_lo_s  = b_i[NUMBITS-2:0];
   assign a_msb_s = a_i[MSB];
   assign b_msb_s = b_i[MSB];

   // The wide sum is split at the MSB: the low part only has to tell whether
   // it carries into the MSB, which a magnitude compare answers directly.
   //   a_lo + b_lo  >= 2^(N-1)  <=>  a_lo >  ~b_lo
   //   a_lo + ~b_lo + 1 >= 2^(N-1) <=> a_lo >= b_lo
   assign c_add_s    = (a_lo_s > ~b_lo_s);
   assign c_sub_s    = (a_lo_s >= b_lo_s);
   assign cout_add_s = (a_msb_s & b_msb_s) | (c_add_s & (a_msb_s ^ b_msb_s));
   assign cout_sub_s = (a_msb_s & ~b_msb_s) | (c_sub_s & ~(a_msb_s ^ b_msb_s));

   // Per-opcode flag selection; signed overflow is carry-in XOR carry-out of the MSB
   always_comb begin
      carry_o    = 1'b0;
      overflow_o = 1'b0;
      case (alu_op_e'(opcode_i))
         OP_ADD_U: carry_o    = cout_add_s;
         OP_ADD_S: overflow_o = c_add_s ^ cout_add_s;
         OP_SUB_U: carry_o    = ~cout_sub_s;
         OP_SUB_S: overflow_o = c_sub_s ^ cout_sub_s;
         OP_SHL:   carry_o    = a_msb_s;
         default: begin
            carry_o    = 1'b0;
            overflow_o = 1'b0;
         end
      endcase
   end

endmodule : alu_flag_gen

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Accepts one command at a time, holds its operands on the ALU interface for
// ALU_LATENCY cycles, captures the registered ALU result and offers it with
// locally generated carry/overflow until the consumer takes it.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_opcode, cmd_a, cmd_b, cmd_tag  command payload
//   alu_reset                       reset to the external ALU (= reset)
//   alu_a, alu_b, alu_opcode        ALU operands, driven from hold registers
//   alu_result, alu_zero            registered ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_tag  response payload
//   ops_done                        wrapping count of completed responses
// -----------------------------------------------------------------------------
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int NUMBITS     = 32,
   parameter int ALU_LATENCY = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_opcode,
   input  logic [NUMBITS-1:0] cmd_a,
   input  logic [NUMBITS-1:0] cmd_b,
   input  logic [3:0]         cmd_tag,
   output logic               alu_reset,
   output logic [NUMBITS-1:0] alu_a,
   output logic [NUMBITS-1:0] alu_b,
   output logic [2:0]         alu_opcode,
   input  logic [NUMBITS-1:0] alu_result,
   input  logic               alu_zero,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [NUMBITS-1:0] rsp_result,
   output logic               rsp_zero,
   output logic               rsp_carry,
   output logic               rsp_overflow,
   output logic [3:0]         rsp_tag,
   output logic [15:0]        ops_done
);

   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LATENCY);

   seq_state_e         state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [NUMBITS-1:0] a_q, a_d;
   logic [NUMBITS-1:0] b_q, b_d;
   logic [3:0]         tag_q, tag_d;
   logic [LAT_W-1:0]   cnt_q, cnt_d;
   logic [NUMBITS-1:0] res_q, res_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;
   logic [3:0]         rtag_q, rtag_d;
   logic [15:0]        ops_done_q, ops_done_d;
   logic               carry_s;
   logic               ovf_s;
   logic               rsp_hs_s;

   // Flags depend only on the held operands, so they are settled long before capture
   alu_flag_gen #(
      .NUMBITS (NUMBITS)
   ) u_flag_gen (
      .opcode_i   (op_q),
      .a_i        (a_q),
      .b_i        (b_q),
      .carry_o    (carry_s),
      .overflow_o (ovf_s)
   );

   assign rsp_hs_s = (state_q == ST_RESP) && rsp_ready;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) state_d = ST_ISSUE;
            else           state_d = ST_IDLE;
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (cnt_q == 4'd1) state_d = ST_RESP;
            else               state_d = ST_WAIT;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
            else           state_d = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs, decoded straight from the state register
   always_comb begin
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         ST_IDLE: cmd_ready = 1'b1;
         ST_RESP: rsp_valid = 1'b1;
         default: begin
            cmd_ready = 1'b0;
            rsp_valid = 1'b0;
         end
      endcase
   end

   // Datapath next-state: command hold, latency count, response capture, op count
   always_comb begin
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      tag_d      = tag_q;
      cnt_d      = cnt_q;
      res_d      = res_q;
      zero_d     = zero_q;
      carry_d    = carry_q;
      ovf_d      = ovf_q;
      rtag_d     = rtag_q;
      ops_done_d = ops_done_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d  = cmd_opcode;
               a_d   = cmd_a;
               b_d   = cmd_b;
               tag_d = cmd_tag;
            end else begin
               op_d  = op_q;
            end
         end
         ST_ISSUE: cnt_d = LAT_LOAD;
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            // Count of 1 marks the cycle the ALU result is valid
            if (cnt_q == 4'd1) begin
               res_d   = alu_result;
               zero_d  = alu_zero;
               carry_d = carry_s;
               ovf_d   = ovf_s;
               rtag_d  = tag_q;
            end else begin
               res_d   = res_q;
            end
         end
         ST_RESP: begin
            if (rsp_hs_s) ops_done_d = ops_done_q + 16'd1;
            else          ops_done_d = ops_done_q;
         end
         default: cnt_d = cnt_q;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q       <= 3'd0;
         a_q        <= {NUMBITS{1'b0}};
         b_q        <= {NUMBITS{1'b0}};
         tag_q      <= 4'd0;
         cnt_q      <= {LAT_W{1'b0}};
         res_q      <= {NUMBITS{1'b0}};
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         ovf_q      <= 1'b0;
         rtag_q     <= 4'd0;
         ops_done_q <= 16'd0;
      end else begin
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         tag_q      <= tag_d;
         cnt_q      <= cnt_d;
         res_q      <= res_d;
         zero_q     <= zero_d;
         carry_q    <= carry_d;
         ovf_q      <= ovf_d;
         rtag_q     <= rtag_d;
         ops_done_q <= ops_done_d;
      end
   end

   assign alu_reset    = reset;
   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_opcode   = op_q;
   assign rsp_result   = res_q;
   assign rsp_zero     = zero_q;
   assign rsp_carry    = carry_q;
   assign rsp_overflow = ovf_q;
   assign rsp_tag      = rtag_q;
   assign ops_done     = ops_done_q;

endmodule : alu_sequencer

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Directed bench for alu_sequencer with a behavioural registered ALU attached.
// u_dut1 uses ALU_LATENCY=1, u_dut3 uses ALU_LATENCY=3. Expected responses
// are pushed to a scoreboard queue when a command is driven and popped when
// the response appears.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

   typedef struct packed {
      logic [31:0] result;
      logic        zero;
      logic        carry;
      logic        ovf;
      logic [3:0]  tag;
   } exp_t;

   logic        clk;
   logic        rst1, rst3;
   logic        cv1, cv3;
   logic        rsp_ready;
   logic [2:0]  cmd_opcode;
   logic [31:0] cmd_a, cmd_b;
   logic [3:0]  cmd_tag;

   logic        cr1, rv1, rz1, rc1, ro1, alu_rst1;
   logic [31:0] rr1, aa1, ab1;
   logic [2:0]  ao1;
   logic [3:0]  rt1;
   logic [15:0] ops1;
   logic [31:0] p1;
   logic        z1;

   logic        cr3, rv3, rz3, rc3, ro3, alu_rst3;
   logic [31:0] rr3, aa3, ab3;
   logic [2:0]  ao3;
   logic [3:0]  rt3;
   logic [15:0] ops3;
   logic [31:0] p3 [3];
   logic        z3 [3];

   int          n_vec = 0;
   int          n_err = 0;
   exp_t        sbq [$];
   logic [15:0] ops_exp [2];

   alu_sequencer #(.NUMBITS(32), .ALU_LATENCY(1)) u_dut1 (
      .clk(clk), .reset(rst1), .cmd_valid(cv1), .cmd_ready(cr1),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
      .alu_reset(alu_rst1), .alu_a(aa1), .alu_b(ab1), .alu_opcode(ao1),
      .alu_result(p1), .alu_zero(z1),
      .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_result(rr1), .rsp_zero(rz1),
      .rsp_carry(rc1), .rsp_overflow(ro1), .rsp_tag(rt1), .ops_done(ops1)
   );

   alu_sequencer #(.NUMBITS(32), .ALU_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(rst3), .cmd_valid(cv3), .cmd_ready(cr3),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
      .alu_reset(alu_rst3), .alu_a(aa3), .alu_b(ab3), .alu_opcode(ao3),
      .alu_result(p3[2]), .alu_zero(z3[2]),
      .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_result(rr3), .rsp_zero(rz3),
      .rsp_carry(rc3), .rsp_overflow(ro3), .rsp_tag(rt3), .ops_done(ops3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0, 3'd1: return a + b;
         3'd2, 3'd3: return a - b;
         3'd4:       return a & b;
         3'd5:       return a | b;
         3'd6:       return a ^ b;
         default:    return a << 1;
      endcase
   endfunction

   // Behavioural ALU, one register stage
   always @(posedge clk) begin
      if (alu_rst1) begin
         p1 <= 32'd0;
         z1 <= 1'b0;
      end else begin
         p1 <= alu_fn(ao1, aa1, ab1);
         z1 <= (alu_fn(ao1, aa1, ab1) == 32'd0);
      end
   end

   // Behavioural ALU, three register stages
   always @(posedge clk) begin
      if (alu_rst3) begin
         for (int k = 0; k < 3; k++) begin
            p3[k] <= 32'd0;
            z3[k] <= 1'b0;
         end
      end else begin
         p3[0] <= alu_fn(ao3, aa3, ab3);
         z3[0] <= (alu_fn(ao3, aa3, ab3) == 32'd0);
         p3[1] <= p3[0];
         z3[1] <= z3[0];
         p3[2] <= p3[1];
         z3[2] <= z3[1];
      end
   end

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      exp_t   e;
      longint sa, sb, s;
      e.result = alu_fn(op, a, b);
      e.zero   = (e.result == 32'd0);
      e.carry  = 1'b0;
      e.ovf    = 1'b0;
      e.tag    = tag;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         3'd0: e.carry = ((longint'(a) + longint'(b)) > 64'sd4294967295);
         3'd1: begin
            s = sa + sb;
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd2: e.carry = (a < b);
         3'd3: begin
            s = sa - sb;
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd7: e.carry = a[31];
         default: e.carry = 1'b0;
      endcase
      return e;
   endfunction

   function automatic exp_t grab(input bit sel);
      exp_t g;
      g.result = sel ? rr3 : rr1;
      g.zero   = sel ? rz3 : rz1;
      g.carry  = sel ? rc3 : rc1;
      g.ovf    = sel ? ro3 : ro1;
      g.tag    = sel ? rt3 : rt1;
      return g;
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, expv);
      end
   endtask

   task automatic chk_rsp(input string pfx, input exp_t g, input exp_t e);
      chk({pfx, "_result"}, {32'd0, g.result}, {32'd0, e.result});
      chk({pfx, "_zero"},   {63'd0, g.zero},   {63'd0, e.zero});
      chk({pfx, "_carry"},  {63'd0, g.carry},  {63'd0, e.carry});
      chk({pfx, "_ovf"},    {63'd0, g.ovf},    {63'd0, e.ovf});
      chk({pfx, "_tag"},    {60'd0, g.tag},    {60'd0, e.tag});
   endtask

   // One command through one instance; stall = cycles rsp_ready is held low after rsp_valid
   task automatic run_op(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input int exp_lat, input int stall);
      int   lat;
      exp_t e;
      @(negedge clk);
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_tag    = tag;
      if (sel) cv3 = 1'b1; else cv1 = 1'b1;
      chk("cmd_ready_idle", {63'd0, (sel ? cr3 : cr1)}, 64'd1);
      sbq.push_back(model(op, a, b, tag));
      @(posedge clk);
      #1;
      cv1 = 1'b0;
      cv3 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(sel ? rv3 : rv1) && lat < 40);
      chk("rsp_latency", 64'(lat), 64'(exp_lat));
      if (!(sel ? rv3 : rv1)) begin
         if (sbq.size() > 0) void'(sbq.pop_front());
         return;
      end
      chk("alu_a_held", {32'd0, (sel ? aa3 : aa1)}, {32'd0, a});
      e = sbq[0];
      for (int k = 0; k < stall; k++) begin
         // offer a competing command while busy; it must be ignored
         if (sel) cv3 = 1'b1; else cv1 = 1'b1;
         cmd_tag = ~tag;
         @(negedge clk);
         chk("stall_valid", {63'd0, (sel ? rv3 : rv1)}, 64'd1);
         chk("stall_cmd_ready", {63'd0, (sel ? cr3 : cr1)}, 64'd0);
         chk_rsp("stall", grab(sel), e);
      end
      cv1 = 1'b0;
      cv3 = 1'b0;
      rsp_ready = 1'b1;
      if (sbq.size() == 0) begin
         chk("sb_nonempty", 64'd0, 64'd1);
      end else begin
         e = sbq.pop_front();
         chk_rsp("rsp", grab(sel), e);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      ops_exp[sel] = ops_exp[sel] + 16'd1;
      @(negedge clk);
      chk("ops_done", {48'd0, (sel ? ops3 : ops1)}, {48'd0, ops_exp[sel]});
      chk("back_to_idle", {63'd0, (sel ? cr3 : cr1)}, 64'd1);
   endtask

   // cmd_valid and rsp_ready held high: exactly one accept every 4 cycles
   task automatic back_to_back();
      exp_t e;
      @(negedge clk);
      rsp_ready  = 1'b1;
      cv1        = 1'b1;
      cmd_opcode = 3'd0;
      cmd_b      = 32'd100;
      for (int i = 0; i < 16; i++) begin
         chk("b2b_ready", {63'd0, cr1}, {63'd0, ((i % 4) == 0)});
         if (rv1) begin
            if (sbq.size() == 0) begin
               chk("b2b_sb_nonempty", 64'd0, 64'd1);
            end else begin
               e = sbq.pop_front();
               chk_rsp("b2b", grab(1'b0), e);
            end
            ops_exp[0] = ops_exp[0] + 16'd1;
         end
         if (cr1) begin
            cmd_a   = 32'(i * 3 + 1);
            cmd_tag = 4'(i);
            sbq.push_back(model(3'd0, cmd_a, cmd_b, cmd_tag));
         end
         @(negedge clk);
      end
      cv1       = 1'b0;
      rsp_ready = 1'b0;
      chk("b2b_ops_done", {48'd0, ops1}, {48'd0, ops_exp[0]});
   endtask

   initial begin
      rst1 = 1'b1; rst3 = 1'b1;
      cv1 = 1'b0; cv3 = 1'b0; rsp_ready = 1'b0;
      cmd_opcode = 3'd0; cmd_a = 32'd0; cmd_b = 32'd0; cmd_tag = 4'd0;
      ops_exp[0] = 16'd0; ops_exp[1] = 16'd0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("alu_reset_follows", {63'd0, alu_rst1}, 64'd1);
      rst1 = 1'b0; rst3 = 1'b0;
      #1;
      chk("alu_reset_low", {63'd0, alu_rst1}, 64'd0);
      @(negedge clk);
      chk("rst_cmd_ready", {63'd0, cr1}, 64'd1);
      chk("rst_rsp_valid", {63'd0, rv1}, 64'd0);
      chk("rst_ops_done", {48'd0, ops1}, 64'd0);
      chk("rst_rsp_result", {32'd0, rr1}, 64'd0);
      chk("rst_cmd_ready3", {63'd0, cr3}, 64'd1);

      // Arithmetic and flag cases, latency 1
      run_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 4'h1, 3, 0);
      run_op(1'b0, 3'd1, 32'h7FFF_FFFF, 32'h0000_0001, 4'h2, 3, 0);
      run_op(1'b0, 3'd3, 32'h8000_0000, 32'h0000_0001, 4'h4, 3, 0);
      run_op(1'b0, 3'd2, 32'h0000_0003, 32'h0000_0005, 4'hA, 3, 5);
      run_op(1'b0, 3'd4, 32'h0000_F0F0, 32'h0000_0F0F, 4'h5, 3, 0);
      run_op(1'b0, 3'd6, 32'h1234_5678, 32'hFFFF_0000, 4'h6, 3, 1);
      run_op(1'b0, 3'd0, 32'h8000_0000, 32'h7FFF_FFFF, 4'h7, 3, 0);

      // Throughput
      back_to_back();

      // Counter wrap: preload near the top instead of running 65536 responses
      @(negedge clk);
      force u_dut1.ops_done_q = 16'hFFFE;
      @(negedge clk);
      release u_dut1.ops_done_q;
      ops_exp[0] = 16'hFFFE;
      chk("ops_preload", {48'd0, ops1}, 64'hFFFE);
      run_op(1'b0, 3'd5, 32'h0000_00F0, 32'h0000_000F, 4'h8, 3, 0);
      run_op(1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h9, 3, 0);

      // Reset while in WAIT drops the operation
      @(negedge clk);
      cmd_opcode = 3'd0; cmd_a = 32'd5; cmd_b = 32'd6; cmd_tag = 4'hC;
      cv1 = 1'b1;
      @(posedge clk);
      #1;
      cv1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("wait_no_valid", {63'd0, rv1}, 64'd0);
      rst1 = 1'b1;
      @(posedge clk);
      #1;
      rst1 = 1'b0;
      ops_exp[0] = 16'd0;
      @(negedge clk);
      chk("postrst_cmd_ready", {63'd0, cr1}, 64'd1);
      chk("postrst_ops_done", {48'd0, ops1}, 64'd0);
      for (int k = 0; k < 4; k++) begin
         chk("postrst_no_valid", {63'd0, rv1}, 64'd0);
         @(negedge clk);
      end
      run_op(1'b0, 3'd2, 32'h0000_0009, 32'h0000_0002, 4'h3, 3, 0);

      // Latency 3 instance
      run_op(1'b1, 3'd7, 32'h8000_0001, 32'h0000_0000, 4'hE, 5, 0);
      run_op(1'b1, 3'd3, 32'h0000_0010, 32'h0000_0010, 4'h1, 5, 2);

      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_alu_sequencer

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter NUMBITS, default 32: operand/result width.
REQ-002 SHALL have parameter ALU_LATENCY, default 1: cycles from operands applied to ALU result valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_opcode  input  3  ALU opcode.
REQ-008 SHALL have port cmd_a, cmd_b  input  NUMBITS  operands.
REQ-009 SHALL have port cmd_tag  input  4  caller tag, echoed on response.
REQ-010 SHALL have port alu_reset  output  1  reset to the ALU.
REQ-011 SHALL have ports alu_a, alu_b  output  NUMBITS; alu_opcode  output  3: ALU operands/opcode.
REQ-012 SHALL have ports alu_result  input  NUMBITS; alu_zero  input  1: registered ALU outputs.
REQ-013 SHALL have port rsp_valid  output  1  response held.
REQ-014 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-015 SHALL have ports rsp_result  output  NUMBITS; rsp_zero, rsp_carry, rsp_overflow  output  1; rsp_tag  output  4.
REQ-016 SHALL have port ops_done  output  16  count of completed responses.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-018 cmd_ready SHALL be high only in IDLE; other states ignore cmd_valid.
REQ-019 IDLE with cmd_valid high SHALL latch opcode, A, B and tag into hold registers, then go to ISSUE.
REQ-020 alu_a/alu_b/alu_opcode SHALL be driven from hold registers at all times (stable from ISSUE through WAIT).
REQ-021 ISSUE SHALL last exactly one cycle, then go to WAIT with latency counter loaded to ALU_LATENCY.
REQ-022 WAIT SHALL decrement the counter each cycle; when it reaches 1, alu_result and alu_zero SHALL be captured into rsp_result and rsp_zero, and the FSM SHALL go to RESP.
REQ-023 With ALU_LATENCY=1, cmd accept to rsp_valid high SHALL be 3 cycles; minimum issue interval SHALL be 4 cycles.
REQ-024 rsp_carry and rsp_overflow SHALL be computed locally from hold operands, on NUMBITS+1-bit sums:
  - op0: carry = bit NUMBITS of A+B; overflow = 0.
  - op1: overflow = (A[MSB]==B[MSB]) and sum[MSB]!=A[MSB]; carry = 0.
  - op2: carry = borrow (A < B unsigned); overflow = 0.
  - op3: overflow = (A[MSB]!=B[MSB]) and diff[MSB]!=A[MSB]; carry = 0.
  - op7: carry = A[MSB]; overflow = 0.
  - op4/5/6: both 0.
REQ-025 RESP SHALL hold rsp_valid and all rsp_* stable until rsp_ready; on rsp_valid&&rsp_ready the FSM SHALL return to IDLE.
REQ-026 ops_done SHALL increment by 1 on each response handshake and wrap 0xFFFF -> 0x0000.
REQ-027 rsp_ready high outside RESP SHALL have no effect.

Reset
REQ-028 alu_reset SHALL equal reset combinationally.
REQ-029 On reset the FSM SHALL enter IDLE; rsp_valid, rsp_*, hold registers, latency counter and ops_done SHALL clear to 0.
REQ-030 Reset in ISSUE, WAIT or RESP SHALL drop the in-flight operation with no response; cmd_ready SHALL be high the cycle after reset deasserts.

Structure
REQ-031 Opcode constants (ADD_U=0, ADD_S=1, SUB_U=2, SUB_S=3, AND=4, OR=5, XOR=6, SHL=7) and FSM state encodings SHALL live in the shared ALU package.
REQ-032 Flag computation SHALL be one combinational sub-module, alu_flag_gen; the FSM, counters and registers SHALL stay in alu_sequencer.

Verification
REQ-033 The bench SHALL cover: op0 A=0xFFFFFFFF B=0x1 -> rsp_result=0, zero=1, carry=1, overflow=0, rsp_valid 3 cycles after accept.
REQ-034 The bench SHALL cover: op1 A=0x7FFFFFFF B=0x1 -> result=0x80000000, overflow=1, carry=0; op3 A=0x80000000 B=0x1 -> result=0x7FFFFFFF, overflow=1.
REQ-035 The bench SHALL cover: op2 A=0x3 B=0x5 tag=0xA -> result=0xFFFFFFFE, carry=1, rsp_tag=0xA; rsp_ready held low 5 cycles -> outputs stable, cmd_ready low throughout.
REQ-036 The bench SHALL cover: back-to-back cmd_valid with rsp_ready=1 -> accepts exactly every 4 cycles; ops_done preloaded by 65536 responses wraps to 0.
REQ-037 The bench SHALL cover: reset asserted in WAIT -> no rsp_valid, ops_done=0, cmd_ready=1 the cycle after deassert.
REQ-038 The bench SHALL cover: ALU_LATENCY=3, op7 A=0x80000001 -> result=0x2, carry=1, rsp_valid 5 cycles after accept.
